// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_ctrl memory controller.
package mem_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Default parameter values
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 1024;
    localparam int DEF_LATENCY = 2;

    // Legal access latency range and the counter width that covers it
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

    // Width of a word index into an array of the given depth (at least 1 bit)
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with per-byte-lane write enables and an
// asynchronous read port. Contents are deliberately never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                          Clock,
    input  logic                          wr_en,
    input  logic [idx_width(DEPTH)-1:0]   idx,
    input  logic [DATA_W/8-1:0]           byte_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             rd_data
);

    localparam int LANES = DATA_W / 8;

    // Replace only the enabled byte lanes of the old word
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [LANES-1:0]  lanes
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < LANES; b++) begin
            if (lanes[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Byte-lane write into the selected word
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem_r[idx] <= merge_lanes(mem_r[idx], wr_data, byte_en);
        end
    end

    assign rd_data = mem_r[idx];

endmodule

// File: rtl/mem_ctrl.sv
// Single-port memory controller with a fixed, parameterised access latency.
// Optional build macro MEM_ERR_CHECK_EN: flags out-of-range, misaligned and
// simultaneous read+write requests with Error and suppresses their effect.
// Without it, Error is tied low, indices wrap modulo DEPTH and a combined
// read+write performs the write only.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic [ADDR_W-1:0]   Address,
    input  logic                ReadEn,
    input  logic                WriteEn,
    input  logic [DATA_W/8-1:0] ByteEn,
    input  logic [DATA_W-1:0]   WriteData,
    output logic [DATA_W-1:0]   ReadData,
    output logic                Ready,
    output logic                Busy,
    output logic                Error
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = idx_width(DEPTH);

    generate
        if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_lat_bad
            $fatal(1, "mem_ctrl: LATENCY must lie in 1..15");
        end
        if ((DATA_W % 8) != 0) begin : g_width_bad
            $fatal(1, "mem_ctrl: DATA_W must be a multiple of 8");
        end
    endgenerate

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [ADDR_W-1:0]    addr_r, addr_s;
    logic [LANES-1:0]     be_r, be_s;
    logic [DATA_W-1:0]    wdata_r, wdata_s;
    logic                 rd_r, wr_r, rd_s, wr_s;
    logic                 accept_s, enter_resp_s, err_s;
    logic                 wr_commit_s, rd_load_s;
    logic [31:0]          wrap_s;
    logic [IDX_W-1:0]     arr_idx_s;
    logic [DATA_W-1:0]    arr_rdata_s;
    logic                 ready_r, busy_r, error_r;
    logic [DATA_W-1:0]    rdata_r;
    logic                 unused_wrap_s;

    // Request seen by the datapath: live inputs in IDLE (so LATENCY=1 can
    // complete on the accepting edge), otherwise the latched request
    always_comb begin
        if (state_r == IDLE) begin
            addr_s  = Address;
            be_s    = ByteEn;
            wdata_s = WriteData;
            rd_s    = ReadEn;
            wr_s    = WriteEn;
        end else begin
            addr_s  = addr_r;
            be_s    = be_r;
            wdata_s = wdata_r;
            rd_s    = rd_r;
            wr_s    = wr_r;
        end
    end

    assign wrap_s        = 32'(addr_s[ADDR_W-1:2]) % 32'(DEPTH);
    assign arr_idx_s     = wrap_s[IDX_W-1:0];
    assign unused_wrap_s = ^wrap_s[31:IDX_W];

`ifdef MEM_ERR_CHECK_EN
    assign err_s = (32'(addr_s[ADDR_W-1:2]) >= 32'(DEPTH)) ||
                   (addr_s[1:0] != 2'b00) || (rd_s && wr_s);
`else
    logic unused_lsb_s;
    assign unused_lsb_s = ^addr_s[1:0];
    assign err_s        = 1'b0;
`endif

    // Next-state logic; cnt holds the edges still to go before RESP
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (ReadEn || WriteEn) begin
                    accept_s = 1'b1;
                    if (LATENCY == 1) begin
                        state_s      = RESP;
                        enter_resp_s = 1'b1;
                        cnt_s        = {CNT_W{1'b0}};
                    end else begin
                        state_s = WAIT;
                        cnt_s   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                cnt_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_s      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Completion side effects; the array has no reset, so commits are
    // blocked while nReset is held to discard any write in flight
    always_comb begin
        wr_commit_s = enter_resp_s && wr_s && !err_s && nReset;
        rd_load_s   = enter_resp_s && rd_s && !wr_s && !err_s;
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .Clock   (Clock),
        .wr_en   (wr_commit_s),
        .idx     (arr_idx_s),
        .byte_en (be_s),
        .wr_data (wdata_s),
        .rd_data (arr_rdata_s)
    );

    // FSM state, latency counter and request latch
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
            be_r    <= {LANES{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                addr_r  <= Address;
                be_r    <= ByteEn;
                wdata_r <= WriteData;
                rd_r    <= ReadEn;
                wr_r    <= WriteEn;
            end
        end
    end

    // Registered handshake outputs and read data
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            error_r <= 1'b0;
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            ready_r <= enter_resp_s;
            busy_r  <= (state_s != IDLE);
            error_r <= enter_resp_s && err_s;
            if (rd_load_s) begin
                rdata_r <= arr_rdata_s;
            end
        end
    end

    assign Ready    = ready_r;
    assign Busy     = busy_r;
    assign Error    = error_r;
    assign ReadData = rdata_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: three instances at LATENCY 2, 3 and 1
// share address/data stimulus; expected completions go through a scoreboard.
module tb_mem_ctrl;

    logic        Clock = 1'b0;
    logic        nReset;
    logic [15:0] Address;
    logic [3:0]  ByteEn;
    logic [31:0] WriteData;
    logic        re [3];
    logic        we [3];
    logic [31:0] rdata [3];
    logic        rdy [3];
    logic        bsy [3];
    logic        err [3];

    always #5 Clock = ~Clock;

    mem_ctrl #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .LATENCY(2)) u_l2 (
        .Clock(Clock), .nReset(nReset), .Address(Address), .ReadEn(re[0]),
        .WriteEn(we[0]), .ByteEn(ByteEn), .WriteData(WriteData),
        .ReadData(rdata[0]), .Ready(rdy[0]), .Busy(bsy[0]), .Error(err[0]));

    mem_ctrl #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .LATENCY(3)) u_l3 (
        .Clock(Clock), .nReset(nReset), .Address(Address), .ReadEn(re[1]),
        .WriteEn(we[1]), .ByteEn(ByteEn), .WriteData(WriteData),
        .ReadData(rdata[1]), .Ready(rdy[1]), .Busy(bsy[1]), .Error(err[1]));

    mem_ctrl #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .LATENCY(1)) u_l1 (
        .Clock(Clock), .nReset(nReset), .Address(Address), .ReadEn(re[2]),
        .WriteEn(we[2]), .ByteEn(ByteEn), .WriteData(WriteData),
        .ReadData(rdata[2]), .Ready(rdy[2]), .Busy(bsy[2]), .Error(err[2]));

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } sb_t;

    sb_t         sbq [$];
    int          total = 0;
    int          bad   = 0;
    int          lat [3] = '{2, 3, 1};
    logic [31:0] mm [3][1024];
    logic [31:0] hold [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input bit rd, input bit wr, input logic [15:0] a);
`ifdef MEM_ERR_CHECK_EN
        return (rd && wr) || (a[1:0] != 2'b00) || ((int'(a) >> 2) >= 1024);
`else
        return (rd && wr && a[0]) && 1'b0;
`endif
    endfunction

    // One request on instance i; called at a negedge, returns at a negedge
    task automatic access(input int i, input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input string tag);
        sb_t e;
        int  n;
        int  idx;
        bit  e_err;
        e_err = model_err(rd, wr, addr);
        idx   = (int'(addr) >> 2) % 1024;
        if (!e_err && wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mm[i][idx][8*b +: 8] = wd[8*b +: 8];
        end else if (!e_err && rd) begin
            hold[i] = mm[i][idx];
        end
        e.data = hold[i];
        e.err  = e_err;
        sbq.push_back(e);
        Address = addr; ByteEn = be; WriteData = wd; re[i] = rd; we[i] = wr;
        @(posedge Clock);
        @(negedge Clock);
        re[i] = 1'b0; we[i] = 1'b0;
        chk({tag, "_busy"}, 32'(bsy[i]), 32'd1);
        n = 1;
        while (!rdy[i] && n < 20) begin
            @(negedge Clock);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat[i]));
        e = sbq.pop_front();
        chk({tag, "_rdata"}, rdata[i], e.data);
        chk({tag, "_error"}, 32'(err[i]), 32'(e.err));
        @(negedge Clock);
        chk({tag, "_ready_pulse"}, 32'(rdy[i]), 32'd0);
        chk({tag, "_idle"}, 32'(bsy[i]), 32'd0);
    endtask

    initial begin
        sb_t e;
        int  pulses;
        int  last;
        nReset = 1'b0; Address = 16'h0; ByteEn = 4'h0; WriteData = 32'h0;
        for (int i = 0; i < 3; i++) begin
            re[i] = 1'b0; we[i] = 1'b0; hold[i] = 32'h0;
        end
        repeat (2) @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", 32'(rdy[i]), 32'd0);
            chk("reset_busy",  32'(bsy[i]), 32'd0);
            chk("reset_error", 32'(err[i]), 32'd0);
            chk("reset_rdata", rdata[i], 32'h0);
        end
        nReset = 1'b1;
        @(negedge Clock);

        // Test 1: full write then read, LATENCY=2
        access(0, 1'b0, 1'b1, 16'h0010, 4'hF, 32'h12345678, "t1_wr");
        access(0, 1'b1, 1'b0, 16'h0010, 4'h0, 32'h0, "t1_rd");
        chk("t1_value", rdata[0], 32'h12345678);

        // Test 2: partial-lane overwrite
        access(0, 1'b0, 1'b1, 16'h0020, 4'hF, 32'h55557777, "t2_wr_full");
        access(0, 1'b0, 1'b1, 16'h0020, 4'b0101, 32'hAAAAAAAA, "t2_wr_lanes");
        access(0, 1'b1, 1'b0, 16'h0020, 4'h0, 32'h0, "t2_rd");
        chk("t2_value", rdata[0], 32'h55AA77AA);

        // Test 3: ReadEn held for 10 edges at LATENCY=3
        access(1, 1'b0, 1'b1, 16'h0010, 4'hF, 32'h13572468, "t3_wr");
        hold[1] = mm[1][4];
        for (int k = 0; k < 3; k++) begin
            e.data = hold[1]; e.err = 1'b0;
            sbq.push_back(e);
        end
        pulses = 0; last = -1;
        Address = 16'h0010; re[1] = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge Clock);
            if (j == 9) re[1] = 1'b0;
            if (rdy[1]) begin
                pulses++;
                if (last >= 0) chk("t3_gap", 32'(j - last), 32'd4);
                last = j;
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("t3_rdata", rdata[1], e.data);
                end else begin
                    chk("t3_pulses_overrun", 32'(pulses), 32'd3);
                end
            end
        end
        chk("t3_pulses", 32'(pulses), 32'd3);
        chk("t3_first_ready", 32'(last - 8), 32'd2);
        sbq.delete();

        // Test 4: reset while a write waits
        access(0, 1'b0, 1'b1, 16'h0040, 4'hF, 32'h11112222, "t4_prior");
        Address = 16'h0040; WriteData = 32'h80050000; ByteEn = 4'hF; we[0] = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        we[0] = 1'b0;
        chk("t4_busy_wait", 32'(bsy[0]), 32'd1);
        nReset = 1'b0;
        #1;
        chk("t4_rst_ready", 32'(rdy[0]), 32'd0);
        chk("t4_rst_busy",  32'(bsy[0]), 32'd0);
        chk("t4_rst_error", 32'(err[0]), 32'd0);
        chk("t4_rst_rdata", rdata[0], 32'h0);
        for (int i = 0; i < 3; i++) hold[i] = 32'h0;
        @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        access(0, 1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, "t4_rd");
        chk("t4_value", rdata[0], 32'h11112222);

        // Test 5: out-of-range and misaligned addresses
        access(0, 1'b0, 1'b1, 16'h0000, 4'hF, 32'hDEADBEEF, "t5_wr0");
        access(0, 1'b1, 1'b0, 16'h1000, 4'h0, 32'h0, "t5_rd_oor");
        access(0, 1'b0, 1'b1, 16'h0002, 4'hF, 32'h0BADCAFE, "t5_wr_mis");
        access(0, 1'b1, 1'b0, 16'h0000, 4'h0, 32'h0, "t5_rd0");
`ifdef MEM_ERR_CHECK_EN
        chk("t5_no_change", rdata[0], 32'hDEADBEEF);
`else
        chk("t5_alias", rdata[0], 32'h0BADCAFE);
`endif

        // Test 6: LATENCY=1 with read and write together
        access(2, 1'b0, 1'b1, 16'h0000, 4'hF, 32'hCAFEF00D, "t6_wr0");
        access(2, 1'b0, 1'b1, 16'h0004, 4'hF, 32'h00000000, "t6_wr4");
        access(2, 1'b1, 1'b0, 16'h0000, 4'h0, 32'h0, "t6_rd0");
        access(2, 1'b1, 1'b1, 16'h0004, 4'hF, 32'h01234567, "t6_rdwr");
        chk("t6_rdata_held", rdata[2], 32'hCAFEF00D);
        access(2, 1'b1, 1'b0, 16'h0004, 4'h0, 32'h0, "t6_rd4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
